// File: rtl/simd_lane_accum.sv
// SIMD lane accumulator: sums NLANES independent LANE_W-bit lanes over ACC_LEN valid samples.
// Optional lane saturation on overflow is enabled by `define SIMD_ACCUM_SATURATE_EN.
module simd_lane_accum #(
  parameter int NLANES  = 4,
  parameter int LANE_W  = 12,
  parameter int ACC_LEN = 16,
  parameter int INREG   = 1,
  parameter int SIGNED  = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic [NLANES*LANE_W-1:0]       dat_i,
  input  logic                           valid_i,
  output logic [NLANES*LANE_W-1:0]       dat_o,
  output logic                           valid_o,
  output logic [NLANES-1:0]              ovf_o,
  output logic [$clog2(ACC_LEN+1)-1:0]   cnt_o
);

  localparam int DW = NLANES * LANE_W;
  localparam int CW = $clog2(ACC_LEN + 1);

  logic [DW-1:0]     r_acc;
  logic [NLANES-1:0] r_ovf;
  logic [CW-1:0]     r_cnt;
  logic              r_vld;

  logic [DW-1:0]     w_as_dat;
  logic              w_as_vld;
  logic [DW-1:0]     w_add;
  logic [NLANES-1:0] w_lane_ovf;
  logic [CW-1:0]     w_cnt_inc;
  logic [DW-1:0]     w_acc_nxt;
  logic [NLANES-1:0] w_ovf_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_vld_nxt;

  // Optional input stage; clr_i kills the sample entering it so it never reaches AS.
  if (INREG != 0) begin : g_inreg
    logic [DW-1:0] r_in_dat;
    logic          r_in_vld;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_in_dat <= '0;
        r_in_vld <= 1'b0;
      end else begin
        r_in_dat <= dat_i;
        r_in_vld <= valid_i & ~clr_i;
      end
    end

    assign w_as_dat = r_in_dat;
    assign w_as_vld = r_in_vld;
  end else begin : g_noinreg
    assign w_as_dat = dat_i;
    assign w_as_vld = valid_i;
  end

  // Per-lane adder, isolated so no carry crosses a lane boundary.
  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    logic [LANE_W-1:0] w_a, w_b, w_sum, w_res;
    logic              w_carry, w_ovf;

    assign w_a = r_acc[k*LANE_W +: LANE_W];
    assign w_b = w_as_dat[k*LANE_W +: LANE_W];
    assign {w_carry, w_sum} = {1'b0, w_a} + {1'b0, w_b};
    assign w_ovf = (SIGNED != 0)
                 ? ((w_a[LANE_W-1] == w_b[LANE_W-1]) && (w_sum[LANE_W-1] != w_a[LANE_W-1]))
                 : w_carry;
`ifdef SIMD_ACCUM_SATURATE_EN
    localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};
    localparam logic [LANE_W-1:0] UMAX = {LANE_W{1'b1}};
    assign w_res = !w_ovf ? w_sum : (SIGNED == 0) ? UMAX : (w_a[LANE_W-1] ? SMIN : SMAX);
`else
    assign w_res = w_sum;
`endif
    assign w_add[k*LANE_W +: LANE_W] = w_res;
    assign w_lane_ovf[k]             = w_ovf;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_ovf <= '0;
      r_cnt <= '0;
      r_vld <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
      r_cnt <= w_cnt_nxt;
      r_vld <= w_vld_nxt;
    end
  end

  // Frame state lives in the counter: zero means the next sample starts a new frame.
  always_comb begin
    w_cnt_inc = r_cnt + CW'(1);
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf;
    w_cnt_nxt = r_cnt;
    w_vld_nxt = 1'b0;
    if (clr_i) begin
      w_cnt_nxt = '0;
      w_ovf_nxt = '0;
    end else if (w_as_vld) begin
      if (r_cnt == '0) begin
        w_acc_nxt = w_as_dat;
        w_ovf_nxt = '0;
      end else begin
        w_acc_nxt = w_add;
        w_ovf_nxt = r_ovf | w_lane_ovf;
      end
      if (w_cnt_inc == CW'(ACC_LEN)) begin
        w_cnt_nxt = '0;
        w_vld_nxt = 1'b1;
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
    end
  end

  always_comb begin
    dat_o   = r_acc;
    valid_o = r_vld;
    ovf_o   = r_ovf;
    cnt_o   = r_cnt;
  end

endmodule

// File: tb/tb_simd_lane_accum.sv
// Directed testbench for simd_lane_accum: four instances cover frame lengths 4/2/1,
// both input-register settings and unsigned lanes, all sharing one stimulus bus.
module tb_simd_lane_accum;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic [47:0] datIn;
  logic        validIn;

  logic [47:0] a4Dat, a2Dat, a4nDat, a1Dat;
  logic        a4Vld, a2Vld, a4nVld, a1Vld;
  logic [3:0]  a4Ovf, a2Ovf, a4nOvf, a1Ovf;
  logic [2:0]  a4Cnt, a4nCnt;
  logic [1:0]  a2Cnt;
  logic [0:0]  a1Cnt;

  int nVectors = 0;
  int nMiscompares = 0;

  always #5 clock = ~clock;

  // ACC_LEN=4, INREG=1, signed
  simd_lane_accum #(.NLANES(4), .LANE_W(12), .ACC_LEN(4), .INREG(1), .SIGNED(1)) u_a4 (
    .clk_i(clock), .rst_i(reset), .clr_i(clear), .dat_i(datIn), .valid_i(validIn),
    .dat_o(a4Dat), .valid_o(a4Vld), .ovf_o(a4Ovf), .cnt_o(a4Cnt));

  // ACC_LEN=2, INREG=1, signed
  simd_lane_accum #(.NLANES(4), .LANE_W(12), .ACC_LEN(2), .INREG(1), .SIGNED(1)) u_a2 (
    .clk_i(clock), .rst_i(reset), .clr_i(clear), .dat_i(datIn), .valid_i(validIn),
    .dat_o(a2Dat), .valid_o(a2Vld), .ovf_o(a2Ovf), .cnt_o(a2Cnt));

  // ACC_LEN=4, INREG=0, signed
  simd_lane_accum #(.NLANES(4), .LANE_W(12), .ACC_LEN(4), .INREG(0), .SIGNED(1)) u_a4n (
    .clk_i(clock), .rst_i(reset), .clr_i(clear), .dat_i(datIn), .valid_i(validIn),
    .dat_o(a4nDat), .valid_o(a4nVld), .ovf_o(a4nOvf), .cnt_o(a4nCnt));

  // ACC_LEN=1, INREG=1, unsigned
  simd_lane_accum #(.NLANES(4), .LANE_W(12), .ACC_LEN(1), .INREG(1), .SIGNED(0)) u_a1 (
    .clk_i(clock), .rst_i(reset), .clr_i(clear), .dat_i(datIn), .valid_i(validIn),
    .dat_o(a1Dat), .valid_o(a1Vld), .ovf_o(a1Ovf), .cnt_o(a1Cnt));

  function automatic logic [47:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [47:0] v;
    v[11:0]  = l0[11:0];
    v[23:12] = l1[11:0];
    v[35:24] = l2[11:0];
    v[47:36] = l3[11:0];
    return v;
  endfunction

  // Drive one cycle of inputs, then let the edge happen and settle before checks.
  task automatic applyStimulus(input logic [47:0] d, input logic v, input logic c);
    datIn   = d;
    validIn = v;
    clear   = c;
    @(posedge clock);
    #1;
  endtask

  task automatic resetAll();
    reset = 1'b1;
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus('0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(pack4(7, 7, 7, 7), 1'b1, 1'b0);
      if (a4Dat !== 48'h0) begin $display("[TB] FAIL reset dat_o cyc%0d: got %h want 0", i, a4Dat); nMiscompares++; end
      nVectors++;
      if (a4Vld !== 1'b0) begin $display("[TB] FAIL reset valid_o cyc%0d: got %b want 0", i, a4Vld); nMiscompares++; end
      nVectors++;
      if (a4Ovf !== 4'h0) begin $display("[TB] FAIL reset ovf_o cyc%0d: got %h want 0", i, a4Ovf); nMiscompares++; end
      nVectors++;
      if (a4Cnt !== 3'd0) begin $display("[TB] FAIL reset cnt_o cyc%0d: got %0d want 0", i, a4Cnt); nMiscompares++; end
      nVectors++;
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus('0, 1'b0, 1'b0);
      if ({a4Dat, a4Vld, a4Ovf, a4Cnt} !== 56'h0) begin
        $display("[TB] FAIL post-reset state cyc%0d: got dat=%h vld=%b ovf=%h cnt=%0d want all 0", i, a4Dat, a4Vld, a4Ovf, a4Cnt);
        nMiscompares++;
      end
      nVectors++;
    end
  endtask

  task automatic test_back_to_back();
    resetAll();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(pack4(1, 2, 3, -1), 1'b1, 1'b0);
      if (a4Vld !== 1'b0) begin $display("[TB] FAIL b2b early valid_o s%0d: got %b want 0", i, a4Vld); nMiscompares++; end
      nVectors++;
    end
    applyStimulus(pack4(5, 5, 5, 5), 1'b1, 1'b0);
    if (a4Vld !== 1'b1) begin $display("[TB] FAIL b2b valid_o: got %b want 1", a4Vld); nMiscompares++; end
    nVectors++;
    if (a4Dat !== pack4(4, 8, 12, -4)) begin $display("[TB] FAIL b2b dat_o: got %h want %h", a4Dat, pack4(4, 8, 12, -4)); nMiscompares++; end
    nVectors++;
    if (a4Ovf !== 4'h0) begin $display("[TB] FAIL b2b ovf_o: got %h want 0", a4Ovf); nMiscompares++; end
    nVectors++;
    if (a4Cnt !== 3'd0) begin $display("[TB] FAIL b2b cnt_o at frame end: got %0d want 0", a4Cnt); nMiscompares++; end
    nVectors++;
    applyStimulus('0, 1'b0, 1'b0);
    if (a4Vld !== 1'b0) begin $display("[TB] FAIL b2b valid_o pulse width: got %b want 0", a4Vld); nMiscompares++; end
    nVectors++;
    if (a4Dat !== pack4(5, 5, 5, 5)) begin $display("[TB] FAIL b2b next frame load: got %h want %h", a4Dat, pack4(5, 5, 5, 5)); nMiscompares++; end
    nVectors++;
    if (a4Cnt !== 3'd1) begin $display("[TB] FAIL b2b next frame cnt_o: got %0d want 1", a4Cnt); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_overflow();
    logic [11:0] lane0Exp;
`ifdef SIMD_ACCUM_SATURATE_EN
    lane0Exp = 12'h7FF;
`else
    lane0Exp = 12'h800;
`endif
    resetAll();
    applyStimulus(pack4(2047, 0, 0, 0), 1'b1, 1'b0);
    applyStimulus(pack4(1, 0, 0, 0), 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    if (a2Vld !== 1'b1) begin $display("[TB] FAIL ovf valid_o: got %b want 1", a2Vld); nMiscompares++; end
    nVectors++;
    if (a2Ovf !== 4'b0001) begin $display("[TB] FAIL ovf ovf_o: got %b want 0001", a2Ovf); nMiscompares++; end
    nVectors++;
    if (a2Dat[11:0] !== lane0Exp) begin $display("[TB] FAIL ovf lane0: got %h want %h", a2Dat[11:0], lane0Exp); nMiscompares++; end
    nVectors++;
    if (a2Dat[47:12] !== 36'h0) begin $display("[TB] FAIL ovf cross-lane carry: got %h want 0", a2Dat[47:12]); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_clear();
    resetAll();
    applyStimulus(pack4(7, 7, 7, 7), 1'b1, 1'b0);
    applyStimulus(pack4(7, 7, 7, 7), 1'b1, 1'b0);
    applyStimulus(pack4(9, 9, 9, 9), 1'b1, 1'b1);
    if (a4Cnt !== 3'd0) begin $display("[TB] FAIL clr cnt_o: got %0d want 0", a4Cnt); nMiscompares++; end
    nVectors++;
    if (a4Dat !== pack4(7, 7, 7, 7)) begin $display("[TB] FAIL clr dat_o hold: got %h want %h", a4Dat, pack4(7, 7, 7, 7)); nMiscompares++; end
    nVectors++;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(pack4(1, 1, 1, 1), 1'b1, 1'b0);
      if (a4Vld !== 1'b0) begin $display("[TB] FAIL clr early valid_o s%0d: got %b want 0", i, a4Vld); nMiscompares++; end
      nVectors++;
      if (i == 0 && a4Cnt !== 3'd0) begin $display("[TB] FAIL clr inreg kill cnt_o: got %0d want 0", a4Cnt); nMiscompares++; end
      if (i == 0) nVectors++;
    end
    applyStimulus('0, 1'b0, 1'b0);
    if (a4Vld !== 1'b1) begin $display("[TB] FAIL clr frame valid_o: got %b want 1", a4Vld); nMiscompares++; end
    nVectors++;
    if (a4Dat !== pack4(4, 4, 4, 4)) begin $display("[TB] FAIL clr frame dat_o: got %h want %h", a4Dat, pack4(4, 4, 4, 4)); nMiscompares++; end
    nVectors++;
    applyStimulus('0, 1'b0, 1'b0);
    if (a4Vld !== 1'b0) begin $display("[TB] FAIL clr extra valid_o: got %b want 0", a4Vld); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_gaps();
    int gaps [4] = '{0, 3, 1, 2};
    resetAll();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        applyStimulus(pack4(100, 100, 100, 100), 1'b0, 1'b0);
        if (a4nCnt !== 3'(i)) begin $display("[TB] FAIL gap cnt_o hold s%0d: got %0d want %0d", i, a4nCnt, i); nMiscompares++; end
        nVectors++;
      end
      applyStimulus(pack4(1, 2, 3, -1), 1'b1, 1'b0);
      if (a4nVld !== (i == 3)) begin $display("[TB] FAIL gap valid_o s%0d: got %b want %b", i, a4nVld, (i == 3)); nMiscompares++; end
      nVectors++;
    end
    if (a4nDat !== pack4(4, 8, 12, -4)) begin $display("[TB] FAIL gap dat_o: got %h want %h", a4nDat, pack4(4, 8, 12, -4)); nMiscompares++; end
    nVectors++;
    applyStimulus('0, 1'b0, 1'b0);
    if (a4nVld !== 1'b0) begin $display("[TB] FAIL gap valid_o pulse width: got %b want 0", a4nVld); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_passthrough();
    resetAll();
    applyStimulus(pack4(12'hFFF, 0, 0, 0), 1'b1, 1'b0);
    applyStimulus(pack4(12'h001, 0, 0, 0), 1'b1, 1'b0);
    if (a1Vld !== 1'b1) begin $display("[TB] FAIL pass valid_o #1: got %b want 1", a1Vld); nMiscompares++; end
    nVectors++;
    if (a1Dat !== 48'hFFF) begin $display("[TB] FAIL pass dat_o #1: got %h want fff", a1Dat); nMiscompares++; end
    nVectors++;
    applyStimulus('0, 1'b0, 1'b0);
    if (a1Vld !== 1'b1) begin $display("[TB] FAIL pass valid_o #2: got %b want 1", a1Vld); nMiscompares++; end
    nVectors++;
    if (a1Dat !== 48'h001) begin $display("[TB] FAIL pass dat_o #2: got %h want 001", a1Dat); nMiscompares++; end
    nVectors++;
    if (a1Ovf !== 4'h0) begin $display("[TB] FAIL pass ovf_o: got %h want 0", a1Ovf); nMiscompares++; end
    nVectors++;
    applyStimulus('0, 1'b0, 1'b0);
    if (a1Vld !== 1'b0) begin $display("[TB] FAIL pass trailing valid_o: got %b want 0", a1Vld); nMiscompares++; end
    nVectors++;
  endtask

  initial begin
    reset   = 1'b1;
    clear   = 1'b0;
    datIn   = '0;
    validIn = 1'b0;
    test_reset();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_gaps();
    test_passthrough();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
